// File: rtl/clk_div_if.sv
// Control and output bundle of the programmable clock divider.
// master = the block configuring the divider, slave = the divider itself.
interface clk_div_if #(
  parameter int DIV_RATIO_WIDTH = 8
);
  logic                       i_clk_en;
  logic [DIV_RATIO_WIDTH-1:0] i_div_ratio;
  logic                       o_div_clk;

  modport master (
    output i_clk_en,
    output i_div_ratio,
    input  o_div_clk
  );

  modport slave (
    input  i_clk_en,
    input  i_div_ratio,
    output o_div_clk
  );
endinterface

// File: rtl/clk_div.sv
// Integer clock divider: o_div_clk = i_ref_clk / N, with ref-clock bypass when disabled or N < 2.
// Optional macro CLKDIV_DUTY50_EN adds a falling-edge flop that gives odd N a 50% duty cycle.
module clk_div #(
  parameter int DIV_RATIO_WIDTH = 8
) (
  input  logic     i_ref_clk,
  input  logic     i_rst_n,
  clk_div_if.slave bus
);

  typedef enum logic {
    ST_BYP,
    ST_RUN
  } state_t;

  localparam logic [DIV_RATIO_WIDTH-1:0] ONE = DIV_RATIO_WIDTH'(1);

  state_t                     state_q, state_d;
  logic [DIV_RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_RATIO_WIDTH-1:0] ratio_q, ratio_d;
  logic                       div_q, div_d;
  logic                       divide_en;
  logic                       div_out;

  // Mode select depends only on registered ratio, so i_div_ratio never reaches the output combinationally.
  assign divide_en = bus.i_clk_en && (ratio_q > ONE);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_BYP;
      cnt_q   <= '0;
      ratio_q <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    div_d   = div_q;
    if (!divide_en) begin
      // Bypass holds the counter at its period-start value, so the ratio keeps being captured.
      state_d = ST_BYP;
      cnt_d   = '0;
      ratio_d = bus.i_div_ratio;
      div_d   = 1'b0;
    end else begin
      if ((state_q == ST_BYP) || (cnt_q == ratio_q - ONE)) begin
        cnt_d   = '0;
        ratio_d = bus.i_div_ratio;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      if (ratio_d > ONE) begin
        state_d = ST_RUN;
        div_d   = (cnt_d < (ratio_d >> 1));
      end else begin
        state_d = ST_BYP;
        cnt_d   = '0;
        div_d   = 1'b0;
      end
    end
  end

`ifdef CLKDIV_DUTY50_EN
  logic ext_q;

  // Holds the high phase half a ref period past the falling edge of div_q for odd ratios.
  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ext_q <= 1'b0;
    end else begin
      ext_q <= div_q & ratio_q[0];
    end
  end

  assign div_out = div_q | ext_q;
`else
  assign div_out = div_q;
`endif

  assign bus.o_div_clk = i_rst_n & (divide_en ? div_out : i_ref_clk);

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: reset, ratio changes at period boundaries, bypass, enable drop, mid-run reset.
module tb_clk_div;
  localparam int W = 8;
`ifdef CLKDIV_DUTY50_EN
  localparam bit DUTY50 = 1'b1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  logic ref_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  clk_div_if #(.DIV_RATIO_WIDTH(W)) bus ();

  clk_div #(.DIV_RATIO_WIDTH(W)) dut (
    .i_ref_clk (ref_clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pos();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge ref_clk);
    #1;
  endtask

  // One sample per ref period, starting at the first period of a fresh ratio.
  task automatic run_div(input string tag, input int n, input int periods);
    logic exp;
    for (int p = 0; p < periods; p++) begin
      for (int k = 0; k < n; k++) begin
        pos();
        exp = (k < n / 2) || (DUTY50 && (n % 2 == 1) && (k == n / 2));
        check($sformatf("%s_p%0d_k%0d", tag, p, k), bus.o_div_clk, exp);
      end
    end
  endtask

  task automatic check_byp(input string tag, input int periods);
    for (int p = 0; p < periods; p++) begin
      pos();
      check($sformatf("%s_hi%0d", tag, p), bus.o_div_clk, 1'b1);
      neg();
      check($sformatf("%s_lo%0d", tag, p), bus.o_div_clk, 1'b0);
    end
  endtask

  initial begin
    bus.i_clk_en    = 1'b0;
    bus.i_div_ratio = '0;

    // Reset holds the output low regardless of the reference phase.
    pos();
    check("rst_hi", bus.o_div_clk, 1'b0);
    neg();
    check("rst_lo", bus.o_div_clk, 1'b0);
    pos();
    rst_n = 1'b1;
    #1;
    check("byp_rel_hi", bus.o_div_clk, 1'b1);
    neg();
    check("byp_rel_lo", bus.o_div_clk, 1'b0);

    // N=6: one latency period low, then 3 high / 3 low.
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd6;
    pos();
    check("lat6", bus.o_div_clk, 1'b0);
    run_div("n6", 6, 2);

    // Mid-period change to 8 leaves the running 6-period intact.
    for (int k = 0; k < 3; k++) begin
      pos();
      check($sformatf("n6tail_hi%0d", k), bus.o_div_clk, 1'b1);
    end
    bus.i_div_ratio = 8'd8;
    for (int k = 0; k < 3; k++) begin
      pos();
      check($sformatf("n6tail_lo%0d", k), bus.o_div_clk, 1'b0);
    end
    run_div("n8", 8, 2);
    bus.i_div_ratio = 8'd2;
    run_div("n2", 2, 3);
    bus.i_div_ratio = 8'd9;
    run_div("n9", 9, 2);

    // N=1 and N=0 pass the reference straight through.
    bus.i_div_ratio = 8'd1;
    check_byp("n1", 3);
    bus.i_div_ratio = 8'd0;
    check_byp("n0", 3);

    // N=11, then drop enable mid high phase.
    bus.i_div_ratio = 8'd11;
    pos();
    check("lat11", bus.o_div_clk, 1'b0);
    run_div("n11", 11, 1);
    for (int k = 0; k < 4; k++) begin
      pos();
      check($sformatf("n11part%0d", k), bus.o_div_clk, 1'b1);
    end
    neg();
    check("pre_drop", bus.o_div_clk, 1'b1);
    bus.i_clk_en = 1'b0;
    #1;
    check("drop_imm", bus.o_div_clk, 1'b0);
    check_byp("en0", 3);

    // Re-enable with N=7 starts a fresh period.
    bus.i_div_ratio = 8'd7;
    bus.i_clk_en    = 1'b1;
    #1;
    check("reen_lo", bus.o_div_clk, 1'b0);
    run_div("n7", 7, 2);

    // Reset mid high phase of N=8.
    bus.i_div_ratio = 8'd8;
    run_div("n8b", 8, 1);
    for (int k = 0; k < 2; k++) begin
      pos();
      check($sformatf("n8bpart%0d", k), bus.o_div_clk, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid", bus.o_div_clk, 1'b0);
    neg();
    check("rst_mid_lo", bus.o_div_clk, 1'b0);
    pos();
    check("rst_mid_hi", bus.o_div_clk, 1'b0);
    rst_n = 1'b1;
    pos();
    check("lat8r", bus.o_div_clk, 1'b0);
    run_div("n8r", 8, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
